// File: rtl/aes_pkg.sv
// Rijndael state layout shared by ShiftRows, MixColumns and the key schedule.
// Byte k = r + 4c sits at bits [W-1-8k -: 8] of a W-bit state, matching FIPS-197 order.
package aes_pkg;

  localparam int NB_AES   = 4;
  localparam int CNT_W    = 16;

  function automatic int sr_bytes(input int nb);
    return 4 * nb;
  endfunction

  localparam int SR_BYTES = sr_bytes(NB_AES);

  // Rijndael-256 widens the row 2/3 offsets to 3/4; NB=4 and NB=6 use r.
  function automatic int shift_off(input int nb, input int r);
    return (nb == 8 && r >= 2) ? r + 1 : r;
  endfunction

  function automatic int byte_idx(input int r, input int c);
    return r + 4 * c;
  endfunction

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte rewire for an NB-column state.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] in_state,
  input  logic             inv,
  output logic [32*NB-1:0] out_state
);

  localparam int W = 32 * NB;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int S  = shift_off(NB, r);
      localparam int DK = byte_idx(r, c);
      localparam int FK = byte_idx(r, (c + S) % NB);
      localparam int IK = byte_idx(r, (c + NB - S) % NB);
      assign out_state[W-1-8*DK -: 8] = inv ? in_state[W-1-8*IK -: 8]
                                            : in_state[W-1-8*FK -: 8];
    end
  end

endmodule

// File: rtl/shift_rows_stream.sv
// Handshaked ShiftRows/InvShiftRows stage: registered output plus one skid entry.
//  state | meaning
//  EMPTY | no beat held; out_valid=0, in_ready=1
//  ONE   | output register holds a beat; skid empty, in_ready=1
//  FULL  | output and skid both hold beats; in_ready=0
module shift_rows_stream
  import aes_pkg::*;
#(
  parameter  int NB = 4,
  localparam int W  = 8 * sr_bytes(NB)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [W-1:0]     in_state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_inv,
  output logic [W-1:0]     out_state,
  output logic [CNT_W-1:0] beat_cnt
);

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("shift_rows_stream: NB must be 4, 6 or 8");
  end

  occ_t             state_q, state_d;
  logic [W-1:0]     out_state_q, out_state_d;
  logic             out_inv_q, out_inv_d;
  logic [W-1:0]     skid_state_q, skid_state_d;
  logic             skid_inv_q, skid_inv_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [W-1:0]     perm_state;
  logic             in_fire, out_fire;

  shift_rows_perm #(.NB(NB)) u_perm (
    .in_state  (in_state),
    .inv       (in_inv),
    .out_state (perm_state)
  );

  // Handshake flags decode straight from the occupancy register, so out_ready
  // never reaches in_ready combinationally.
  assign out_valid = (state_q != OCC_EMPTY);
  assign in_ready  = (state_q != OCC_FULL);
  assign out_state = out_state_q;
  assign out_inv   = out_inv_q;
  assign beat_cnt  = beat_cnt_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    out_state_d  = out_state_q;
    out_inv_d    = out_inv_q;
    skid_state_d = skid_state_q;
    skid_inv_d   = skid_inv_q;
    beat_cnt_d   = beat_cnt_q;

    unique case (state_q)
      OCC_EMPTY: begin
        if (in_fire) begin
          out_state_d = perm_state;
          out_inv_d   = in_inv;
          state_d     = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (in_fire && out_fire) begin
          out_state_d = perm_state;
          out_inv_d   = in_inv;
        end else if (in_fire) begin
          skid_state_d = perm_state;
          skid_inv_d   = in_inv;
          state_d      = OCC_FULL;
        end else if (out_fire) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (out_fire) begin
          out_state_d = skid_state_q;
          out_inv_d   = skid_inv_q;
          state_d     = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase

    if (out_fire) beat_cnt_d = beat_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= OCC_EMPTY;
      out_state_q  <= '0;
      out_inv_q    <= 1'b0;
      skid_state_q <= '0;
      skid_inv_q   <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      out_state_q  <= out_state_d;
      out_inv_q    <= out_inv_d;
      skid_state_q <= skid_state_d;
      skid_inv_q   <= skid_inv_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed bench for shift_rows_stream: NB=4 instance with a scoreboard, NB=8 instance for the wide offsets.
module tb_shift_rows_stream;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b1;
  logic [127:0] in_state = '0;
  logic         in_ready, out_valid, out_inv;
  logic [127:0] out_state;
  logic [15:0]  beat_cnt;

  logic         i8_valid = 1'b0, i8_inv = 1'b0, o8_ready = 1'b1;
  logic [255:0] i8_state = '0;
  logic         i8_ready, o8_valid, o8_inv;
  logic [255:0] o8_state;
  logic [15:0]  o8_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic         inv;
    logic [127:0] st;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  shift_rows_stream #(.NB(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv), .out_state(out_state),
    .beat_cnt(beat_cnt)
  );

  shift_rows_stream #(.NB(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(i8_valid), .in_ready(i8_ready), .in_inv(i8_inv), .in_state(i8_state),
    .out_valid(o8_valid), .out_ready(o8_ready), .out_inv(o8_inv), .out_state(o8_state),
    .beat_cnt(o8_cnt)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: build a row/column byte matrix, rotate each row by its offset.
  function automatic logic [255:0] ref_perm(input int nb, input logic [255:0] s, input logic inv);
    logic [7:0]   a [4][8];
    logic [255:0] o;
    int           w, sh, src;
    o = '0;
    w = 32 * nb;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        a[r][c] = s[w-1-8*(r+4*c) -: 8];
    for (int r = 0; r < 4; r++) begin
      sh = (nb == 8 && r > 1) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - sh + nb) % nb : (c + sh) % nb;
        o[w-1-8*(r+4*c) -: 8] = a[r][src];
      end
    end
    return o;
  endfunction

  always @(negedge clk) begin
    exp_t   e;
    logic [255:0] full;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_beat", {255'b0, out_valid}, 256'd0);
        end else begin
          e = sb.pop_front();
          check("sb_out_state", {128'b0, out_state}, {128'b0, e.st});
          check("sb_out_inv", {255'b0, out_inv}, {255'b0, e.inv});
        end
      end
      if (in_valid && in_ready) begin
        full = ref_perm(4, {128'b0, in_state}, in_inv);
        sb.push_back('{inv: in_inv, st: full[127:0]});
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic inv, output int waits);
    in_valid = 1'b1;
    in_state = d;
    in_inv   = inv;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_bound", {255'b0, in_ready}, 256'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_state = '0;
    in_inv   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_bound", {255'b0, out_valid}, 256'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           w, total;
    logic [255:0] seq8, fwd8;
    logic [7:0]   b3;
    logic [127:0] r;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", {255'b0, out_valid}, 256'd0);
    check("rst_in_ready", {255'b0, in_ready}, 256'd1);
    check("rst_beat_cnt", {240'b0, beat_cnt}, 256'd0);
    check("rst_out_state", {128'b0, out_state}, 256'd0);
    check("rst_out_inv", {255'b0, out_inv}, 256'd0);

    // T1 forward FIPS-197 vector, one cycle latency
    out_ready = 1'b1;
    send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, w);
    idle();
    check("t1_out_valid", {255'b0, out_valid}, 256'd1);
    check("t1_out_state", {128'b0, out_state}, {128'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5});
    check("t1_out_inv", {255'b0, out_inv}, 256'd0);
    drain();
    check("t1_hold_state", {128'b0, out_state}, {128'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5});

    // T2 inverse restores the SubBytes output
    send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, w);
    idle();
    check("t2_out_state", {128'b0, out_state}, {128'b0, 128'hd42711aee0bf98f1b8b45de51e415230});
    check("t2_out_inv", {255'b0, out_inv}, 256'd1);
    drain();

    // T3 NB=8 offsets and round trip
    for (int k = 0; k < 32; k++) seq8[255-8*k -: 8] = k[7:0];
    i8_valid = 1'b1; i8_inv = 1'b0; i8_state = seq8;
    @(posedge clk); #1;
    i8_valid = 1'b0;
    check("t3_fwd_valid", {255'b0, o8_valid}, 256'd1);
    b3 = o8_state[231:224];
    check("t3_row3_col0", {248'b0, b3}, 256'h13);
    check("t3_fwd_state", o8_state, ref_perm(8, seq8, 1'b0));
    fwd8 = o8_state;
    i8_valid = 1'b1; i8_inv = 1'b1; i8_state = fwd8;
    @(posedge clk); #1;
    i8_valid = 1'b0;
    check("t3_roundtrip", o8_state, seq8);
    check("t3_inv_flag", {255'b0, o8_inv}, 256'd1);

    // T4 backpressure: A,B fill the stage, C waits for in_ready
    out_ready = 1'b0;
    send(128'h000102030405060708090a0b0c0d0e0f, 1'b0, w);
    send(128'h101112131415161718191a1b1c1d1e1f, 1'b1, w);
    in_state = 128'h202122232425262728292a2b2c2d2e2f;
    in_inv   = 1'b0;
    check("t4_full_in_ready", {255'b0, in_ready}, 256'd0);
    repeat (2) @(posedge clk);
    #1;
    check("t4_still_full", {255'b0, in_ready}, 256'd0);
    out_ready = 1'b1;
    send(128'h202122232425262728292a2b2c2d2e2f, 1'b0, w);
    idle();
    check("t4_c_wait", w, 256'd1);
    drain();
    check("t4_sb_empty", sb.size(), 256'd0);
    check("t4_beat_cnt", {240'b0, beat_cnt}, 256'd5);

    // T5 100 back-to-back beats, alternating mode
    do_reset();
    total = 0;
    for (int i = 0; i < 100; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      send(r, i[0], w);
      total += w;
    end
    idle();
    drain();
    check("t5_no_stall", total, 256'd0);
    check("t5_beat_cnt", {240'b0, beat_cnt}, 256'd100);
    check("t5_sb_empty", sb.size(), 256'd0);

    // T6 reset while FULL, then counter wrap
    out_ready = 1'b0;
    send(128'hdeadbeef000000000000000012345678, 1'b0, w);
    send(128'hcafef00d0000000000000000abcdef01, 1'b1, w);
    idle();
    check("t6_full", {255'b0, in_ready}, 256'd0);
    do_reset();
    check("t6_out_valid", {255'b0, out_valid}, 256'd0);
    check("t6_in_ready", {255'b0, in_ready}, 256'd1);
    check("t6_beat_cnt", {240'b0, beat_cnt}, 256'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (65535) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_inv   = $urandom_range(0, 1);
      @(posedge clk);
      #1;
    end
    idle();
    drain();
    check("t6_cnt_ffff", {240'b0, beat_cnt}, 256'hffff);
    send(128'h0f0e0d0c0b0a09080706050403020100, 1'b1, w);
    idle();
    drain();
    check("t6_cnt_wrap", {240'b0, beat_cnt}, 256'd0);
    check("t6_sb_empty", sb.size(), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
